whirlpool_sbox_stage_seq: RTL and testbench

Sequential, lane-parametrised Whirlpool SubBytes stage. It accepts a full 512-bit state over a valid/ready handshake and substitutes LANES bytes per cycle through LANES `whirlpool_sbox` instances. It returns the substituted state over a second valid/ready handshake. It replaces the fully parallel 64-S-box stage wherever area matters more than throughput in the PBKDF2-HMAC-Whirlpool core.

---
 rtl/whirlpool_pkg.sv | 9 +
 rtl/whirlpool_sbox_stage_seq_if.sv | 12 +
 rtl/whirlpool_sbox.sv | 17 +
 rtl/whirlpool_sbox_stage_seq.sv | 94 +++++++++
 tb/tb_whirlpool_sbox_stage_seq.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/whirlpool_pkg.sv
// whirlpool_pkg: shared state constants, byte-offset helper and FSM state type
package whirlpool_pkg;
  localparam int STATE_BYTES = 64;
  localparam int STATE_BITS = 512;
  typedef enum logic [1:0] {IDLE, BUSY, PIPE, DONE} state_t;
  function automatic int byte_msb(input int k);
    return STATE_BITS - 1 - 8 * k;
  endfunction
endpackage

// File: rtl/whirlpool_sbox_stage_seq_if.sv
// whirlpool_sbox_stage_seq_if: input and output valid/ready channels of the S-box stage
interface whirlpool_sbox_stage_seq_if;
  import whirlpool_pkg::*;
  logic [STATE_BITS-1:0] in_data;
  logic in_valid;
  logic in_ready;
  logic [STATE_BITS-1:0] out_data;
  logic out_valid;
  logic out_ready;
  modport master (output in_data, in_valid, out_ready, input in_ready, out_data, out_valid);
  modport slave (input in_data, in_valid, out_ready, output in_ready, out_data, out_valid);
endinterface

// File: rtl/whirlpool_sbox.sv
// whirlpool_sbox: combinational Whirlpool S-box built from the E, E^-1 and R mini-boxes
module whirlpool_sbox (
  input  logic [7:0] idata,
  output logic [7:0] odata
);
  localparam logic [63:0] E = 64'h1B9CD6F3E874A250;
  localparam logic [63:0] EI = 64'hF0D7BE5A92C13486;
  localparam logic [63:0] R = 64'h7CBDE49F638A2510;
  function automatic logic [3:0] nib(input logic [63:0] t, input logic [3:0] x);
    return t[60 - 4 * int'(x) +: 4];
  endfunction
  logic [3:0] a, b, r;
  assign a = nib(E, idata[7:4]);
  assign b = nib(EI, idata[3:0]);
  assign r = nib(R, a ^ b);
  assign odata = {nib(E, a ^ r), nib(EI, b ^ r)};
endmodule

// File: rtl/whirlpool_sbox_stage_seq.sv
// whirlpool_sbox_stage_seq: sequential SubBytes over LANES bytes/cycle; WHIRLPOOL_SBOX_PIPE_REG_EN adds an S-box output register
module whirlpool_sbox_stage_seq
  import whirlpool_pkg::*;
#(
  parameter int LANES = 8
) (
  input  logic clk,
  input  logic rst_n,
  whirlpool_sbox_stage_seq_if.slave bus,
  output logic busy
);
  localparam int BEATS = STATE_BYTES / LANES;
  localparam int CW = BEATS > 1 ? $clog2(BEATS) : 1;
  localparam int W = 8 * LANES;
  if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 &&
      LANES != 16 && LANES != 32 && LANES != 64) begin : g_bad_lanes
    $error("whirlpool_sbox_stage_seq: LANES must be a power of two from 1 to 64");
  end
  state_t state;
  logic [CW-1:0] cnt;
  logic [STATE_BITS-1:0] sbuf;
  logic [W-1:0] lane_in, lane_out;
  logic last;
  assign lane_in = sbuf[byte_msb(int'(cnt) * LANES) -: W];
  assign last = cnt == CW'(BEATS - 1);
  assign bus.in_ready = state == IDLE || (state == DONE && bus.out_ready);
  assign bus.out_data = sbuf;
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    whirlpool_sbox u_sbox (.idata(lane_in[8*i +: 8]), .odata(lane_out[8*i +: 8]));
  end
`ifdef WHIRLPOOL_SBOX_PIPE_REG_EN
  logic [W-1:0] pipe_q;
  logic [CW-1:0] pidx;
`endif
  // control FSM; the buffer is substituted in place one lane group per beat
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      sbuf <= '0;
      bus.out_valid <= 1'b0;
      busy <= 1'b0;
`ifdef WHIRLPOOL_SBOX_PIPE_REG_EN
      pipe_q <= '0;
      pidx <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          sbuf <= bus.in_data;
          cnt <= '0;
          state <= BUSY;
          busy <= 1'b1;
        end
        BUSY: begin
`ifdef WHIRLPOOL_SBOX_PIPE_REG_EN
          pipe_q <= lane_out;
          pidx <= cnt;
          if (cnt != '0) sbuf[byte_msb(int'(pidx) * LANES) -: W] <= pipe_q;
          if (last) state <= PIPE;
`else
          sbuf[byte_msb(int'(cnt) * LANES) -: W] <= lane_out;
          if (last) begin
            state <= DONE;
            bus.out_valid <= 1'b1;
            busy <= 1'b0;
          end
`endif
          cnt <= last ? '0 : cnt + 1'b1;
        end
`ifdef WHIRLPOOL_SBOX_PIPE_REG_EN
        PIPE: begin
          sbuf[byte_msb(int'(pidx) * LANES) -: W] <= pipe_q;
          state <= DONE;
          bus.out_valid <= 1'b1;
          busy <= 1'b0;
        end
`endif
        DONE: if (bus.out_ready) begin
          bus.out_valid <= 1'b0;
          if (bus.in_valid) begin
            sbuf <= bus.in_data;
            cnt <= '0;
            state <= BUSY;
            busy <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_whirlpool_sbox_stage_seq.sv
// tb_whirlpool_sbox_stage_seq: scoreboard bench for LANES = 1, 8 and 64
module tb_whirlpool_sbox_stage_seq;
`ifdef WHIRLPOOL_SBOX_PIPE_REG_EN
  localparam int PX = 1;
`else
  localparam int PX = 0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [511:0] id[3];
  logic iv[3], ordy[3];
  logic ir[3], ov[3], bsy[3];
  logic [511:0] od[3];
  whirlpool_sbox_stage_seq_if b0 ();
  whirlpool_sbox_stage_seq_if b1 ();
  whirlpool_sbox_stage_seq_if b2 ();
  whirlpool_sbox_stage_seq #(.LANES(1)) u_d1 (.clk(clk), .rst_n(rst_n), .bus(b0), .busy(bsy[0]));
  whirlpool_sbox_stage_seq #(.LANES(8)) u_d8 (.clk(clk), .rst_n(rst_n), .bus(b1), .busy(bsy[1]));
  whirlpool_sbox_stage_seq #(.LANES(64)) u_d64 (.clk(clk), .rst_n(rst_n), .bus(b2), .busy(bsy[2]));
  assign b0.in_data = id[0];
  assign b0.in_valid = iv[0];
  assign b0.out_ready = ordy[0];
  assign ir[0] = b0.in_ready;
  assign ov[0] = b0.out_valid;
  assign od[0] = b0.out_data;
  assign b1.in_data = id[1];
  assign b1.in_valid = iv[1];
  assign b1.out_ready = ordy[1];
  assign ir[1] = b1.in_ready;
  assign ov[1] = b1.out_valid;
  assign od[1] = b1.out_data;
  assign b2.in_data = id[2];
  assign b2.in_valid = iv[2];
  assign b2.out_ready = ordy[2];
  assign ir[2] = b2.in_ready;
  assign ov[2] = b2.out_valid;
  assign od[2] = b2.out_data;
  // free-running clock
  always #5 clk = ~clk;
  int nvec = 0;
  int nerr = 0;
  logic [511:0] exp_q[$];
  logic [511:0] last, ramp;
  time t_acc, t1, t2;
  logic [3:0] ex[16] = '{4'h1, 4'hB, 4'h9, 4'hC, 4'hD, 4'h6, 4'hF, 4'h3,
                         4'hE, 4'h8, 4'h7, 4'h4, 4'hA, 4'h2, 4'h5, 4'h0};
  logic [3:0] rx[16] = '{4'h7, 4'hC, 4'hB, 4'hD, 4'hE, 4'h4, 4'h9, 4'hF,
                         4'h6, 4'h3, 4'h8, 4'hA, 4'h2, 4'h5, 4'h1, 4'h0};
  logic [3:0] ei[16];
  function automatic int beats(input int d);
    return d == 0 ? 64 : d == 1 ? 8 : 1;
  endfunction
  function automatic logic [7:0] sref(input logic [7:0] v);
    logic [3:0] a, c, r;
    a = ex[v[7:4]];
    c = ei[v[3:0]];
    r = rx[a ^ c];
    return {ex[a ^ r], ei[c ^ r]};
  endfunction
  function automatic logic [511:0] sub(input logic [511:0] x);
    logic [511:0] y;
    for (int k = 0; k < 64; k++) y[511-8*k -: 8] = sref(x[511-8*k -: 8]);
    return y;
  endfunction
  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic put(input int d, input logic [511:0] x);
    int n = 0;
    @(negedge clk);
    id[d] = x;
    iv[d] = 1'b1;
    while (!ir[d] && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!ir[d]) check("rdy_timeout", ir[d], 1'b1);
    @(posedge clk);
    t_acc = $time;
    exp_q.push_back(sub(x));
    #1 iv[d] = 1'b0;
  endtask
  task automatic wait_ov(input int d, output time t);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ov[d] && n < 300);
    if (!ov[d]) check("ov_timeout", ov[d], 1'b1);
    t = $time;
  endtask
  task automatic take(input int d);
    if (exp_q.size() == 0) check("queue_empty", 1'b0, 1'b1);
    else check("data", od[d], exp_q.pop_front());
    last = od[d];
    ordy[d] = 1'b1;
    @(posedge clk);
    #1 ordy[d] = 1'b0;
  endtask
  task automatic get(input int d, input int lat);
    time t;
    wait_ov(d, t);
    check("latency", (t - t_acc - 5) / 10, lat);
    take(d);
  endtask
  // stimulus and checks
  initial begin
    for (int i = 0; i < 16; i++) ei[ex[i]] = 4'(i);
    for (int d = 0; d < 3; d++) begin
      id[d] = '0;
      iv[d] = 1'b0;
      ordy[d] = 1'b0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int d = 0; d < 3; d++) begin
      check("rst_ov", ov[d], 1'b0);
      check("rst_busy", bsy[d], 1'b0);
      check("rst_rdy", ir[d], 1'b1);
      check("rst_data", od[d], '0);
    end
    put(1, '0);
    get(1, 8 + PX);
    check("zero_18", last, {64{8'h18}});
    for (int k = 0; k < 64; k++) ramp[511-8*k -: 8] = 8'(k);
    for (int d = 0; d < 3; d++) begin
      put(d, ramp);
      get(d, beats(d) + PX);
      check("a00", last[511 -: 8], 8'h18);
      check("a01", last[503 -: 8], 8'h23);
      check("a02", last[495 -: 8], 8'hC6);
    end
    put(1, '1);
    wait_ov(1, t1);
    last = od[1];
    for (int i = 0; i < 20; i++) begin
      check("hold_data", od[1], last);
      check("hold_rdy", ir[1], 1'b0);
      @(negedge clk);
    end
    check("ff_86", od[1], {64{8'h86}});
    take(1);
    put(1, ramp);
    wait_ov(1, t1);
    id[1] = ~ramp;
    iv[1] = 1'b1;
    ordy[1] = 1'b1;
    #1 check("b2b_rdy", ir[1], 1'b1);
    check("b2b_first", od[1], exp_q.pop_front());
    @(posedge clk);
    t_acc = $time;
    exp_q.push_back(sub(~ramp));
    #1 iv[1] = 1'b0;
    ordy[1] = 1'b0;
    @(negedge clk);
    check("b2b_busy", bsy[1], 1'b1);
    wait_ov(1, t2);
    check("b2b_period", (t2 - t1) / 10, 9 + PX);
    take(1);
    put(1, ramp);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_ov", ov[1], 1'b0);
    check("mid_rst_busy", bsy[1], 1'b0);
    check("mid_rst_rdy", ir[1], 1'b1);
    rst_n = 1'b1;
    exp_q.delete();
    put(1, '0);
    get(1, 8 + PX);
    check("post_rst_18", last, {64{8'h18}});
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
  // hard stop if the run wedges
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
